// File: rtl/pdm_ramp_if.sv
`default_nettype none
// ============================================================================
// pdm_ramp_if : configuration, stream and status bundle for pdm_ramp
// Revision    : 1.0
// ============================================================================
interface pdm_ramp_if #(
    parameter int DWC = 8,
    parameter int CHN = 1
);
    logic                    ena;
    logic [CHN-1:0][DWC-1:0] cfg_tgt;
    logic [DWC-1:0]          cfg_stp;
    logic                    cfg_wen;
    logic                    cfg_clr;
    logic [CHN-1:0][DWC-1:0] str_dat;
    logic                    str_vld;
    logic                    str_rdy;
    logic [CHN-1:0]          sts_bsy;
    logic [CHN-1:0]          sts_don;

    modport master (
        output ena, cfg_tgt, cfg_stp, cfg_wen, cfg_clr, str_rdy,
        input  str_dat, str_vld, sts_bsy, sts_don
    );

    modport slave (
        input  ena, cfg_tgt, cfg_stp, cfg_wen, cfg_clr, str_rdy,
        output str_dat, str_vld, sts_bsy, sts_don
    );
endinterface
`default_nettype wire

// File: rtl/pdm_ramp.sv
`default_nettype none
// ============================================================================
// pdm_ramp : per-channel slew-limited ramp of PDM setpoints toward a target
// Revision : 1.0
// ============================================================================
module pdm_ramp #(
    parameter int DWC = 8,
    parameter int CHN = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pdm_ramp_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_e;

    logic [CHN-1:0][DWC-1:0] cur_q, cur_d;
    logic [CHN-1:0][DWC-1:0] tgt_q, tgt_d;
    state_e                  state_q [CHN];
    state_e                  state_d [CHN];
    logic [CHN-1:0]          don_q, don_d;
    logic [CHN-1:0]          bsy;
    logic                    xfer;

    assign xfer        = bus.ena & bus.str_rdy;
    assign bus.str_vld = bus.ena;
    assign bus.str_dat = cur_q;
    assign bus.sts_don = don_q;
    assign bus.sts_bsy = bsy;

    always_comb begin
        logic [DWC:0] sum;
        logic [DWC:0] dif;
        for (int i = 0; i < CHN; i++) begin
            // One extra bit so the step can never wrap past either rail.
            sum      = {1'b0, cur_q[i]} + {1'b0, bus.cfg_stp};
            dif      = {1'b0, cur_q[i]} - {1'b0, bus.cfg_stp};
            cur_d[i] = cur_q[i];
            tgt_d[i] = tgt_q[i];
            if (bus.cfg_clr) begin
                cur_d[i] = '0;
                tgt_d[i] = '0;
            end else begin
                if (xfer) begin
                    if (bus.cfg_stp == '0)
                        cur_d[i] = tgt_q[i];
                    else if (cur_q[i] < tgt_q[i])
                        cur_d[i] = (sum > {1'b0, tgt_q[i]}) ? tgt_q[i] : sum[DWC-1:0];
                    else if (cur_q[i] > tgt_q[i])
                        cur_d[i] = (dif[DWC] || (dif[DWC-1:0] < tgt_q[i])) ? tgt_q[i] : dif[DWC-1:0];
                end
                // The step above used the old target; the new one lands at the same edge.
                if (bus.cfg_wen)
                    tgt_d[i] = bus.cfg_tgt[i];
            end
            if (cur_d[i] < tgt_d[i])
                state_d[i] = ST_RISE;
            else if (cur_d[i] > tgt_d[i])
                state_d[i] = ST_FALL;
            else
                state_d[i] = ST_IDLE;
            don_d[i] = (state_q[i] != ST_IDLE) && (state_d[i] == ST_IDLE) && !bus.cfg_clr;
            bsy[i]   = (state_q[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= '0;
            tgt_q <= '0;
            don_q <= '0;
            for (int i = 0; i < CHN; i++)
                state_q[i] <= ST_IDLE;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
            don_q <= don_d;
            for (int i = 0; i < CHN; i++)
                state_q[i] <= state_d[i];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pdm_ramp.sv
`default_nettype none
// ============================================================================
// tb_pdm_ramp : directed scenarios plus random traffic against a ramp model
// Revision    : 1.0
// ============================================================================
module tb_pdm_ramp;
    localparam int DWC = 8;
    localparam int CHN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   m_cur [CHN] = '{default: 0};
    int   m_tgt [CHN] = '{default: 0};
    bit   m_don [CHN] = '{default: 0};

    always #5 clk = ~clk;

    pdm_ramp_if #(.DWC(DWC), .CHN(CHN)) bus ();

    pdm_ramp #(.DWC(DWC), .CHN(CHN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: move toward the target by at most the step, never past it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHN; i++) begin
                m_cur[i] = 0; m_tgt[i] = 0; m_don[i] = 0;
            end
        end else begin
            for (int i = 0; i < CHN; i++) begin
                int c, t, nc, nt, s;
                bit busy_before;
                c = m_cur[i]; t = m_tgt[i]; nc = c; nt = t;
                s = int'(bus.cfg_stp);
                busy_before = (c != t);
                if (bus.cfg_clr) begin
                    nc = 0; nt = 0;
                end else begin
                    if (bus.ena && bus.str_rdy) begin
                        if (s == 0)     nc = t;
                        else if (c < t) nc = (c + s > t) ? t : c + s;
                        else if (c > t) nc = (c - s < t) ? t : c - s;
                    end
                    if (bus.cfg_wen) nt = int'(bus.cfg_tgt[i]);
                end
                m_don[i] = busy_before && (nc == nt) && !bus.cfg_clr;
                m_cur[i] = nc;
                m_tgt[i] = nt;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.str_vld !== bus.ena) begin
            errors++;
            $display("FAIL cyc_vld got %0b want %0b", bus.str_vld, bus.ena);
        end
        for (int i = 0; i < CHN; i++) begin
            checks++;
            if (int'(bus.str_dat[i]) != m_cur[i] || $isunknown(bus.str_dat[i])) begin
                errors++;
                $display("FAIL cyc_dat[%0d] t=%0t got %0d want %0d", i, $time, bus.str_dat[i], m_cur[i]);
            end
            checks++;
            if (bus.sts_bsy[i] !== (m_cur[i] != m_tgt[i])) begin
                errors++;
                $display("FAIL cyc_bsy[%0d] t=%0t got %0b want %0b", i, $time, bus.sts_bsy[i], m_cur[i] != m_tgt[i]);
            end
            checks++;
            if (bus.sts_don[i] !== m_don[i]) begin
                errors++;
                $display("FAIL cyc_don[%0d] t=%0t got %0b want %0b", i, $time, bus.sts_don[i], m_don[i]);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse();
        bus.str_rdy = 1'b1;
        tick();
        bus.str_rdy = 1'b0;
    endtask

    task automatic write_tgt(input int t0, input int t1);
        bus.cfg_tgt[0] = 8'(t0);
        bus.cfg_tgt[1] = 8'(t1);
        bus.cfg_wen    = 1'b1;
        tick();
        bus.cfg_wen    = 1'b0;
    endtask

    initial begin
        int seq [4];
        bus.ena = 1'b1; bus.cfg_tgt = '0; bus.cfg_stp = '0;
        bus.cfg_wen = 1'b0; bus.cfg_clr = 1'b0; bus.str_rdy = 1'b0;
        #2;
        lit("rst_vld", int'(bus.str_vld), 1);
        lit("rst_dat0", int'(bus.str_dat[0]), 0);
        lit("rst_bsy", int'(bus.sts_bsy), 0);
        #10 rst = 1'b0;
        tick();

        // Up-ramp 16 per transfer toward 50, channel 1 toward 3.
        bus.cfg_stp = 8'd16;
        write_tgt(50, 3);
        lit("up_bsy", int'(bus.sts_bsy[0]), 1);
        seq = '{16, 32, 48, 50};
        for (int k = 0; k < 4; k++) begin
            idle(3);
            pulse();
            lit($sformatf("up_dat%0d", k), int'(bus.str_dat[0]), seq[k]);
        end
        lit("up_don", int'(bus.sts_don[0]), 1);
        lit("up_bsy_end", int'(bus.sts_bsy[0]), 0);
        tick();
        lit("up_don_gone", int'(bus.sts_don[0]), 0);

        // Down-ramp with clamp at zero.
        bus.cfg_stp = 8'd20;
        write_tgt(0, 3);
        seq = '{30, 10, 0, 0};
        for (int k = 0; k < 3; k++) begin
            pulse();
            lit($sformatf("dn_dat%0d", k), int'(bus.str_dat[0]), seq[k]);
        end
        lit("dn_don", int'(bus.sts_don[0]), 1);

        // No wrap at the top rail.
        bus.cfg_stp = 8'd0;
        write_tgt(250, 3);
        pulse();
        lit("jump250", int'(bus.str_dat[0]), 250);
        bus.cfg_stp = 8'd16;
        write_tgt(255, 3);
        pulse();
        lit("nowrap", int'(bus.str_dat[0]), 255);

        // Jump, then fall, then reverse mid-ramp.
        bus.cfg_stp = 8'd0;
        write_tgt(200, 3);
        pulse();
        lit("jump200", int'(bus.str_dat[0]), 200);
        bus.cfg_stp = 8'd10;
        write_tgt(100, 3);
        pulse(); pulse(); pulse();
        lit("fall170", int'(bus.str_dat[0]), 170);
        write_tgt(180, 3);
        lit("rev_don", int'(bus.sts_don[0]), 0);
        lit("rev_bsy", int'(bus.sts_bsy[0]), 1);
        pulse();
        lit("rev_180", int'(bus.str_dat[0]), 180);
        lit("rev_don_end", int'(bus.sts_don[0]), 1);

        // Same-cycle target write and transfer steps with the old target.
        bus.cfg_clr = 1'b1; tick(); bus.cfg_clr = 1'b0;
        write_tgt(8, 3);
        bus.cfg_stp = 8'd4;
        bus.str_rdy = 1'b1;
        write_tgt(100, 3);
        bus.str_rdy = 1'b0;
        lit("same_cur", int'(bus.str_dat[0]), 4);
        lit("same_bsy", int'(bus.sts_bsy[0]), 1);
        pulse();
        lit("same_next", int'(bus.str_dat[0]), 8);

        // Disabled: pulses ignored, value frozen.
        bus.ena = 1'b0;
        pulse(); pulse();
        lit("ena0_dat", int'(bus.str_dat[0]), 8);
        lit("ena0_vld", int'(bus.str_vld), 0);
        bus.ena = 1'b1;
        pulse();
        lit("ena1_dat", int'(bus.str_dat[0]), 12);

        // Asynchronous reset mid-ramp.
        #2 rst = 1'b1;
        #1;
        lit("arst_dat", int'(bus.str_dat[0]), 0);
        lit("arst_bsy", int'(bus.sts_bsy), 0);
        #2 rst = 1'b0;
        tick();
        lit("arst_don", int'(bus.sts_don), 0);

        // Clear wins over a simultaneous target write.
        bus.cfg_stp = 8'd1;
        bus.cfg_clr = 1'b1;
        write_tgt(77, 77);
        bus.cfg_clr = 1'b0;
        lit("clr_bsy", int'(bus.sts_bsy), 0);
        pulse();
        lit("clr_tgt0", int'(bus.str_dat[0]), 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.ena     = ($urandom_range(0, 9) != 0);
            bus.str_rdy = ($urandom_range(0, 2) == 0);
            bus.cfg_wen = ($urandom_range(0, 24) == 0);
            bus.cfg_clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0)
                bus.cfg_stp = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.cfg_tgt[0] = 8'($urandom);
            bus.cfg_tgt[1] = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
            tick();
        end
        bus.cfg_wen = 1'b0; bus.cfg_clr = 1'b0; bus.str_rdy = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
